// File: rtl/mips_cpu_pc_sequencer.sv
// Program-counter sequencer for the Harvard MIPS core: reset vector, +4 fetch,
// one-slot branch delay, stall hold and halt. Optional macro: MISALIGN_EXC_EN.
module mips_cpu_pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter logic [31:0] HALT_ADDR    = 32'h00000000,
`ifdef MISALIGN_EXC_EN
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00180,
`endif
   parameter int          CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_enable,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_target,
   output logic [31:0]      instr_address,
   output logic             active,
   output logic             in_delay_slot,
   output logic [31:0]      link_addr,
   output logic             ds_redirect_err,
   output logic             exc_pulse,
   output logic [CNT_W-1:0] retired_count
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DELAY  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [31:0]        r_pc, w_pc_nxt;
   logic [31:0]        r_pend, w_pend_nxt;
   logic               r_ds_err, w_ds_err_nxt;
   logic               r_exc, w_exc_nxt;
   logic [CNT_W-1:0]   r_count, w_count_nxt;
   logic               w_adv;
   logic [31:0]        w_redir_tgt;
   logic               w_redir_exc;
   logic               r_pend_exc, w_pend_exc_nxt;

`ifdef MISALIGN_EXC_EN
   assign w_redir_exc = (redirect_target[1:0] != 2'b00);
   assign w_redir_tgt = w_redir_exc ? EXC_VECTOR : redirect_target;
`else
   assign w_redir_exc = 1'b0;
   assign w_redir_tgt = redirect_target & ~32'h3;
`endif

   assign w_adv = clk_enable & ~stall & (r_state != ST_HALTED);

   // NOTE: every next-state value gets its hold default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_pend_nxt     = r_pend;
      w_pend_exc_nxt = r_pend_exc;
      w_ds_err_nxt   = r_ds_err;
      w_exc_nxt      = 1'b0;
      w_count_nxt    = r_count;
      if (w_adv) begin
         w_count_nxt = r_count + CNT_W'(1);
         case (r_state)
            ST_RUN: begin
               w_pc_nxt = r_pc + 32'd4;
               if (redirect_valid) begin
                  w_pend_nxt     = w_redir_tgt;
                  w_pend_exc_nxt = w_redir_exc;
                  w_state_nxt    = ST_DELAY;
               end
            end
            ST_DELAY: begin
               w_pc_nxt = r_pend;
               if (redirect_valid) w_ds_err_nxt = 1'b1;
               // The halt check sees the already-substituted target.
               if (r_pend == HALT_ADDR) begin
                  w_state_nxt = ST_HALTED;
               end else begin
                  w_state_nxt = ST_RUN;
                  w_exc_nxt   = r_pend_exc;
               end
            end
            default: w_state_nxt = ST_RUN;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_RUN;
         r_pc       <= RESET_VECTOR;
         r_pend     <= 32'd0;
         r_pend_exc <= 1'b0;
         r_ds_err   <= 1'b0;
         r_exc      <= 1'b0;
         r_count    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_pend     <= w_pend_nxt;
         r_pend_exc <= w_pend_exc_nxt;
         r_ds_err   <= w_ds_err_nxt;
         r_exc      <= w_exc_nxt;
         r_count    <= w_count_nxt;
      end
   end

   assign instr_address   = r_pc;
   assign active          = (r_state != ST_HALTED);
   assign in_delay_slot   = (r_state == ST_DELAY);
   assign link_addr       = r_pc + 32'd8;
   assign ds_redirect_err = r_ds_err;
   assign exc_pulse       = r_exc;
   assign retired_count   = r_count;

endmodule

// File: tb/tb_mips_cpu_pc_sequencer.sv
// Directed bench for mips_cpu_pc_sequencer: a per-edge reference model checked
// every cycle, plus literal expectations. Honours MISALIGN_EXC_EN.
module tb_mips_cpu_pc_sequencer;

   localparam logic [31:0] RV  = 32'hBFC00000;
   localparam logic [31:0] EXC = 32'hBFC00180;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_enable = 1'b0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'd0;
   logic [31:0] instr_address;
   logic        active;
   logic        in_delay_slot;
   logic [31:0] link_addr;
   logic        ds_redirect_err;
   logic        exc_pulse;
   logic [31:0] retired_count;

   int n_checks = 0;
   int n_bad    = 0;
   bit chk_en   = 1'b0;

   mips_cpu_pc_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .clk_enable      (clk_enable),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .instr_address   (instr_address),
      .active          (active),
      .in_delay_slot   (in_delay_slot),
      .link_addr       (link_addr),
      .ds_redirect_err (ds_redirect_err),
      .exc_pulse       (exc_pulse),
      .retired_count   (retired_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: where the program is, whether a jump is owed after the
   // current slot, and the side flags.
   logic [31:0] m_pc, m_tgt, m_cnt;
   bit          m_halt, m_owed, m_err, m_exc, m_tgt_bad;

   always @(posedge clk) begin
      if (reset) begin
         m_pc = RV; m_tgt = 0; m_cnt = 0;
         m_halt = 0; m_owed = 0; m_err = 0; m_exc = 0; m_tgt_bad = 0;
      end else if (clk_enable && !stall && !m_halt) begin
         m_cnt = m_cnt + 1;
         m_exc = 0;
         if (m_owed) begin
            m_owed = 0;
            m_pc   = m_tgt;
            if (redirect_valid) m_err = 1;
            if (m_tgt == 32'd0) m_halt = 1;
            else m_exc = m_tgt_bad;
         end else begin
            m_pc = m_pc + 4;
            if (redirect_valid) begin
               m_owed = 1;
`ifdef MISALIGN_EXC_EN
               m_tgt_bad = (redirect_target % 4) != 0;
               m_tgt     = m_tgt_bad ? EXC : redirect_target;
`else
               m_tgt_bad = 0;
               m_tgt     = redirect_target - (redirect_target % 4);
`endif
            end
         end
      end else begin
         m_exc = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_pc",     instr_address,   m_pc);
         check("model_link",   link_addr,       m_pc + 8);
         check("model_active", {31'd0, active}, {31'd0, !m_halt});
         check("model_ds",     {31'd0, in_delay_slot},   {31'd0, m_owed});
         check("model_err",    {31'd0, ds_redirect_err}, {31'd0, m_err});
         check("model_exc",    {31'd0, exc_pulse},       {31'd0, m_exc});
         check("model_cnt",    retired_count,   m_cnt);
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; clk_enable = 1'b1; stall = 1'b0;
      redirect_valid = 1'b0; redirect_target = 32'd0;
      @(posedge clk); #1;
   endtask

   task automatic tick(input logic rv, input logic [31:0] tgt, input logic st, input logic en);
      @(negedge clk);
      reset = 1'b0; redirect_valid = rv; redirect_target = tgt;
      stall = st; clk_enable = en;
      @(posedge clk); #1;
   endtask

   initial begin
      // T1: reset and plain +4 advance
      do_reset();
      chk_en = 1'b1;
      check("t1_pc_rst",  instr_address, 32'hBFC00000);
      check("t1_link",    link_addr,     32'hBFC00008);
      check("t1_cnt_rst", retired_count, 32'd0);
      check("t1_act_rst", {31'd0, active}, 32'd1);
      for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 1'b0, 1'b1);
      check("t1_pc3",  instr_address, 32'hBFC0000C);
      check("t1_cnt3", retired_count, 32'd3);

      // T2: branch with delay slot
      do_reset();
      tick(1'b0, 32'd0, 1'b0, 1'b1);
      tick(1'b0, 32'd0, 1'b0, 1'b1);
      check("t2_pc_x", instr_address, 32'hBFC00008);
      tick(1'b1, 32'hBFC00018, 1'b0, 1'b1);
      check("t2_pc_ds", instr_address, 32'hBFC0000C);
      check("t2_ds1",   {31'd0, in_delay_slot}, 32'd1);
      tick(1'b0, 32'd0, 1'b0, 1'b1);
      check("t2_pc_tgt", instr_address, 32'hBFC00018);
      check("t2_ds0",    {31'd0, in_delay_slot}, 32'd0);

      // T3: jump to zero halts
      for (int i = 0; i < 5; i++) tick(1'b0, 32'd0, 1'b0, 1'b1);
      check("t3_pc_2c", instr_address, 32'hBFC0002C);
      tick(1'b1, 32'd0, 1'b0, 1'b1);
      check("t3_pc_30", instr_address, 32'hBFC00030);
      check("t3_act_ds", {31'd0, active}, 32'd1);
      tick(1'b0, 32'd0, 1'b0, 1'b1);
      check("t3_pc_halt",  instr_address, 32'd0);
      check("t3_act_halt", {31'd0, active}, 32'd0);
      check("t3_cnt_halt", retired_count, 32'd11);
      for (int i = 0; i < 5; i++) tick(1'b1, 32'hBFC00123, 1'b0, 1'b1);
      check("t3_pc_hold",  instr_address, 32'd0);
      check("t3_cnt_hold", retired_count, 32'd11);
      check("t3_err_hold", {31'd0, ds_redirect_err}, 32'd0);

      // T4: stall and clock-enable hold inside the delay slot
      do_reset();
      tick(1'b1, 32'hBFC00040, 1'b0, 1'b1);
      tick(1'b0, 32'd0, 1'b1, 1'b1);
      tick(1'b1, 32'hBFC00999, 1'b1, 1'b1);
      check("t4_pc_stall", instr_address, 32'hBFC00004);
      check("t4_ds_stall", {31'd0, in_delay_slot}, 32'd1);
      tick(1'b0, 32'd0, 1'b0, 1'b0);
      tick(1'b1, 32'hBFC00999, 1'b0, 1'b0);
      check("t4_pc_ce",  instr_address, 32'hBFC00004);
      check("t4_cnt_ce", retired_count, 32'd1);
      check("t4_err_ce", {31'd0, ds_redirect_err}, 32'd0);
      tick(1'b0, 32'd0, 1'b0, 1'b1);
      check("t4_pc_tgt", instr_address, 32'hBFC00040);

      // T5: redirect inside a delay slot is ignored but sticky-flagged
      tick(1'b1, 32'hBFC00100, 1'b0, 1'b1);
      tick(1'b1, 32'hBFC00200, 1'b0, 1'b1);
      check("t5_pc_first", instr_address, 32'hBFC00100);
      check("t5_err",      {31'd0, ds_redirect_err}, 32'd1);
      tick(1'b0, 32'd0, 1'b0, 1'b1);
      check("t5_pc_seq", instr_address, 32'hBFC00104);
      check("t5_err_sticky", {31'd0, ds_redirect_err}, 32'd1);
      tick(1'b1, 32'hBFC00300, 1'b0, 1'b1);
      do_reset();
      check("t5_pc_rst",  instr_address, 32'hBFC00000);
      check("t5_err_rst", {31'd0, ds_redirect_err}, 32'd0);
      check("t5_ds_rst",  {31'd0, in_delay_slot}, 32'd0);
      tick(1'b0, 32'd0, 1'b0, 1'b1);
      check("t5_pc_run", instr_address, 32'hBFC00004);

      // T6: misaligned target
      tick(1'b1, 32'hBFC00016, 1'b0, 1'b1);
      tick(1'b0, 32'd0, 1'b0, 1'b1);
`ifdef MISALIGN_EXC_EN
      check("t6_pc_tgt", instr_address, 32'hBFC00180);
      check("t6_exc",    {31'd0, exc_pulse}, 32'd1);
      tick(1'b0, 32'd0, 1'b0, 1'b1);
      check("t6_pc_next", instr_address, 32'hBFC00184);
`else
      check("t6_pc_tgt", instr_address, 32'hBFC00014);
      check("t6_exc",    {31'd0, exc_pulse}, 32'd0);
      tick(1'b0, 32'd0, 1'b0, 1'b1);
      check("t6_pc_next", instr_address, 32'hBFC00018);
`endif
      check("t6_exc_drop", {31'd0, exc_pulse}, 32'd0);

      @(negedge clk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
